// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte sources share one UART encoder.
// Each grant moves one byte, then the FSM follows the encoder's busy handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [7:0]             o_Enc_Byte,
  output logic                   o_Enc_Write_En,
  input  logic                   i_Enc_Busy,
  output logic [1:0]             o_Grant_Id,
  output logic                   o_Active,
  output logic                   o_Timeout_Err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [7:0]    enc_byte_q, enc_byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Requester slots are padded to four so unused indices read as never-valid.
  logic [3:0] valid_ext;
  logic [7:0] byte_ext [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_ext
    if (gi < NUM_REQ) begin : g_used
      assign valid_ext[gi] = i_Req_Valid[gi];
      assign byte_ext[gi]  = i_Req_Byte[8*gi +: 8];
    end else begin : g_unused
      assign valid_ext[gi] = 1'b0;
      assign byte_ext[gi]  = 8'h00;
    end
  end

  logic       hi_found, lo_found;
  logic [1:0] hi_idx, lo_idx;
  logic [1:0] pick_idx;
  logic       grant_fire;

  // Lowest valid index at/after the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 2'd0;
    lo_found = 1'b0;
    lo_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_ext[k]) begin
        lo_found = 1'b1;
        lo_idx   = 2'(k);
        if (2'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 2'(k);
        end
      end
    end
  end

  assign pick_idx   = hi_found ? hi_idx : lo_idx;
  assign grant_fire = i_Rst_L && (state_q == S_IDLE) && lo_found && !i_Enc_Busy;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign o_Req_Ready[gi] = grant_fire && (pick_idx == 2'(gi));
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    enc_byte_d = enc_byte_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_fire) begin
          enc_byte_d = byte_ext[pick_idx];
          grant_id_d = pick_idx;
          ptr_d      = (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_Enc_Busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Encoder ignored the write: drop the byte and flag it, no retry.
          if (cnt_d == CW'(BUSY_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!i_Enc_Busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      grant_id_q <= 2'd0;
      enc_byte_q <= 8'h00;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      enc_byte_q <= enc_byte_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign o_Enc_Byte     = enc_byte_q;
  assign o_Grant_Id     = grant_id_q;
  assign o_Enc_Write_En = (state_q == S_LOAD);
  assign o_Active       = (state_q != S_IDLE);
  assign o_Timeout_Err  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with three requesters.
// A timeline-based reference model predicts grants; a monitor checks each encoder write.
module tb_uart_tx_arbiter;

  localparam int NR  = 3;
  localparam int BT  = 16;
  localparam int INF = 32'h3fff_ffff;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      enc_byte;
  logic            enc_we;
  logic            enc_busy = 1'b0;
  logic            foreign_busy = 1'b0;
  logic            enc_busy_w;
  logic [1:0]      grant_id;
  logic            active;
  logic            terr;

  assign enc_busy_w = enc_busy | foreign_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Req_Valid    (req_valid),
    .i_Req_Byte     (req_byte),
    .o_Req_Ready    (req_ready),
    .o_Enc_Byte     (enc_byte),
    .o_Enc_Write_En (enc_we),
    .i_Enc_Busy     (enc_busy_w),
    .o_Grant_Id     (grant_id),
    .o_Active       (active),
    .o_Timeout_Err  (terr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- requester sources ----------------
  logic [7:0] rq_mem  [NR][256];
  int         rq_life [NR][256];
  int         rq_head [NR];
  int         rq_tail [NR];
  int         rq_age  [NR];

  // life 0 = hold until accepted; life n = withdraw after n cycles if not accepted
  task automatic push_req(input int k, input logic [7:0] b, input int life);
    rq_mem[k][rq_tail[k] % 256]  = b;
    rq_life[k][rq_tail[k] % 256] = life;
    rq_tail[k]++;
  endtask

  function automatic bit drained();
    for (int k = 0; k < NR; k++) if (rq_head[k] != rq_tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  always begin
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      if (rst_n && req_ready[k] && req_valid[k]) begin
        rq_head[k]++;
        rq_age[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (rq_head[k] != rq_tail[k] && rq_life[k][rq_head[k] % 256] != 0 &&
          rq_age[k] >= rq_life[k][rq_head[k] % 256]) begin
        rq_head[k]++;
        rq_age[k] = 0;
      end
      if (rq_head[k] != rq_tail[k]) begin
        req_valid[k]        = 1'b1;
        req_byte[8*k +: 8]  = rq_mem[k][rq_head[k] % 256];
        rq_age[k]++;
      end else begin
        req_valid[k]        = 1'b0;
        req_byte[8*k +: 8]  = 8'($urandom);
      end
    end
  end

  // ---------------- encoder model ----------------
  int enc_delay = 2;
  int enc_len   = 5;
  int rise_cnt  = -1;
  int hold_cnt  = 0;

  always begin
    @(posedge clk);
    #1;
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) enc_busy = 1'b0;
    end
    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        enc_busy = 1'b1;
        hold_cnt = enc_len;
        rise_cnt = -1;
      end
    end
    if (enc_we) rise_cnt = enc_delay;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] wr_log [$];

  int cyc       = 0;
  int free_at   = 0;
  int g_cyc     = -100;
  int m_ptr     = 0;
  int err_at    = INF;
  bit rise_seen = 1'b0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic          e_we, e_act, e_err;
    int            k;
    exp_t          e;
    cyc++;
    exp_rdy = '0;
    if (!rst_n) begin
      m_ptr     = 0;
      free_at   = 0;
      g_cyc     = -100;
      rise_seen = 1'b0;
      err_at    = INF;
      e_we      = 1'b0;
      e_act     = 1'b0;
      e_err     = 1'b0;
      chk("reset_byte", enc_byte, 8'h00);
      chk("reset_grant_id", grant_id, 2'd0);
    end else begin
      e_we  = (cyc == g_cyc + 1);
      e_act = (cyc > g_cyc) && (cyc < free_at);
      e_err = (cyc >= err_at);
      if (cyc >= free_at) begin
        if (!enc_busy_w && req_valid != '0) begin
          k = -1;
          for (int j = 0; j < NR; j++)
            if (k < 0 && req_valid[(m_ptr + j) % NR]) k = (m_ptr + j) % NR;
          exp_rdy[k] = 1'b1;
          e.id = 2'(k);
          e.b  = req_byte[8*k +: 8];
          sb_q.push_back(e);
          m_ptr     = (k + 1) % NR;
          g_cyc     = cyc;
          free_at   = INF;
          rise_seen = 1'b0;
        end
      end else if (cyc >= g_cyc + 2) begin
        if (rise_seen) begin
          if (!enc_busy_w) free_at = cyc + 1;
        end else if (enc_busy_w) begin
          rise_seen = 1'b1;
        end else if (cyc == g_cyc + 1 + BT) begin
          free_at = cyc + 1;
          if (err_at == INF) err_at = cyc + 1;
        end
      end
    end
    chk("ready", req_ready, exp_rdy);
    chk("write_en", enc_we, e_we);
    chk("active", active, e_act);
    chk("timeout_err", terr, e_err);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      sb_q.delete();
    end else if (enc_we) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: byte %0h written with no grant expected at %0t", enc_byte, $time);
      end else begin
        e = sb_q.pop_front();
        chk("enc_byte", enc_byte, e.b);
        chk("grant_id", grant_id, e.id);
        wr_log.push_back(enc_byte);
        $display("write byte=%0h id=%0d t=%0t", enc_byte, grant_id, $time);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_quiet(input int maxc, input string name);
    int n;
    n = 0;
    while (n < maxc && !(drained() && cyc >= free_at && !enc_busy_w)) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      total++;
      bad++;
      $display("FAIL %s: idle not reached within %0d cycles", name, maxc);
    end
    tick();
    tick();
  endtask

  task automatic wait_active(input int maxc, input bit need_busy, input string name);
    int n;
    n = 0;
    while (n < maxc && !(active && (!need_busy || enc_busy_w))) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      total++;
      bad++;
      $display("FAIL %s: arbiter never became active within %0d cycles", name, maxc);
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp [], input int n);
    chk({name, "_count"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) chk(name, wr_log[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp_v [];
    int         fcnt;

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single byte, long frame
    wr_log.delete();
    enc_delay = 2;
    enc_len   = 100;
    push_req(0, 8'h41, 0);
    wait_quiet(400, "t1_idle");
    exp_v = '{8'h41};
    chk_log("t1_log", exp_v, 1);

    // Round robin with three continuously valid sources from pointer 0
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    wr_log.delete();
    enc_len = 5;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) push_req(k, 8'(8'h10 * (k + 1)), 0);
    wait_quiet(400, "t2_idle");
    exp_v = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
    chk_log("t2_log", exp_v, 6);

    // Held off by foreign traffic, then wrap from pointer 2 to requester 0
    wr_log.delete();
    enc_len      = 6;
    foreign_busy = 1'b1;
    push_req(1, 8'hA1, 0);
    repeat (10) tick();
    foreign_busy = 1'b0;
    wait_active(50, 1'b0, "t3_active");
    push_req(0, 8'hB0, 0);
    push_req(1, 8'hB1, 0);
    wait_quiet(400, "t3_idle");
    exp_v = '{8'hA1, 8'hB0, 8'hB1};
    chk_log("t3_log", exp_v, 3);

    // Encoder never responds: timeout, move on, flag sticks
    wr_log.delete();
    enc_delay = 1000;
    push_req(2, 8'hC2, 0);
    push_req(0, 8'hC0, 0);
    wait_quiet(400, "t4_idle");
    @(negedge clk);
    rise_cnt  = -1;
    enc_delay = 2;
    tick();
    exp_v = '{8'hC2, 8'hC0};
    chk_log("t4_log", exp_v, 2);
    chk("t4_err_sticky", terr, 1'b1);

    // Short pulses while the arbiter is busy are never accepted
    wr_log.delete();
    enc_len = 20;
    push_req(0, 8'hD0, 0);
    wait_active(50, 1'b0, "t6_active");
    tick();
    push_req(1, 8'hD1, 1);
    push_req(2, 8'hD2, 2);
    wait_quiet(400, "t6_idle");
    exp_v = '{8'hD0};
    chk_log("t6_log", exp_v, 1);

    // Random traffic, random encoder timing, foreign busy bursts
    fcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(0, NR - 1);
        if (rq_tail[k] - rq_head[k] < 200)
          push_req(k, 8'($urandom), ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      end
      enc_delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4);
      enc_len   = $urandom_range(1, 8);
      if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) foreign_busy = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        fcnt         = $urandom_range(1, 6);
        foreign_busy = 1'b1;
      end
      tick();
    end
    foreign_busy = 1'b0;
    enc_delay    = 2;
    wait_quiet(4000, "rand_idle");
    chk("rand_sb_empty", sb_q.size(), 0);

    // Asynchronous reset while a frame is still shifting out
    wr_log.delete();
    enc_delay = 2;
    enc_len   = 60;
    push_req(0, 8'h55, 0);
    wait_active(50, 1'b1, "t5_active");
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, '0);
    chk("t5_rst_we", enc_we, 1'b0);
    chk("t5_rst_byte", enc_byte, 8'h00);
    chk("t5_rst_id", grant_id, 2'd0);
    chk("t5_rst_active", active, 1'b0);
    chk("t5_rst_err", terr, 1'b0);
    repeat (3) tick();
    #2;
    rst_n = 1'b1;
    push_req(1, 8'h66, 0);
    push_req(0, 8'h77, 0);
    wait_quiet(400, "t5_idle");
    exp_v = '{8'h55, 8'h77, 8'h66};
    chk_log("t5_log", exp_v, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
